// File: rtl/rr_arbiter_ctrl_pkg.sv
// Shared flow-control definitions: state encodings and default sizing for the
// round-robin FIFO arbiter and anything that decodes its state output.
package rr_arbiter_ctrl_pkg;

    localparam int unsigned DEF_N    = 4;
    localparam int unsigned DEF_SELW = 2;
    localparam int unsigned DEF_CNTW = 16;

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_IDLE   = 3'b001,
        ST_ACTIVE = 3'b010,
        ST_PAUSE  = 3'b011,
        ST_ERROR  = 3'b100
    } state_t;

endpackage

// File: rtl/rr_arbiter_ctrl_pick.sv
// Round-robin priority picker: first non-empty source at or above rr_ptr,
// wrapping modulo N, returned as a one-hot grant plus its index.
module rr_pick
    import rr_arbiter_ctrl_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned SELW = DEF_SELW
) (
    input  logic [N-1:0]    empty,
    input  logic [SELW-1:0] rr_ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            valid
);

    int unsigned     pos;
    logic [SELW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos  = (32'(rr_ptr) + k) % N;
            cand = SELW'(pos);
            if (!valid && !empty[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter moving words from N source FIFOs into one destination
// FIFO, with back-pressure pause, sticky overflow error and a push counter.
module rr_arbiter_ctrl
    import rr_arbiter_ctrl_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned SELW = DEF_SELW,
    parameter int unsigned CNTW = DEF_CNTW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iniciar,
    input  logic [N-1:0]    empty,
    input  logic            almost_full,
    input  logic            full,
    output logic [N-1:0]    pop,
    output logic            push,
    output logic [SELW-1:0] sel,
    output logic [2:0]      estado,
    output logic            idle,
    output logic            pausa,
    output logic            error_full,
    output logic [CNTW-1:0] xfer_count
);

    state_t          state, next_state;
    logic [SELW-1:0] rr_ptr, next_ptr;
    logic [N-1:0]    pick_grant;
    logic [SELW-1:0] pick_idx;
    logic            pick_valid;
    logic            any_ready, overflow, grant_en;

    rr_pick #(.N(N), .SELW(SELW)) u_pick (
        .empty  (empty),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign any_ready = ~&empty;
    assign overflow  = push && full && (state != ST_INIT);
    // No new read is started on an overflow cycle: its word could never be written.
    assign grant_en  = (state == ST_ACTIVE) && !overflow && !almost_full && pick_valid;
    assign pop       = grant_en ? pick_grant : '0;
    assign next_ptr  = (pick_idx == SELW'(N - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        next_state = state;
        unique case (state)
            ST_INIT:   if (iniciar) next_state = ST_IDLE;
            ST_IDLE: begin
                if (overflow)       next_state = ST_ERROR;
                else if (any_ready) next_state = almost_full ? ST_PAUSE : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (overflow)         next_state = ST_ERROR;
                else if (almost_full) next_state = ST_PAUSE;
                else if (!any_ready)  next_state = ST_IDLE;
            end
            ST_PAUSE: begin
                if (overflow)         next_state = ST_ERROR;
                else if (!almost_full) next_state = any_ready ? ST_ACTIVE : ST_IDLE;
            end
            ST_ERROR:  next_state = ST_ERROR;
            default:   next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            rr_ptr     <= '0;
            push       <= 1'b0;
            sel        <= '0;
            xfer_count <= '0;
        end else begin
            state <= next_state;
            push  <= grant_en;
            if (grant_en) begin
                sel    <= pick_idx;
                rr_ptr <= next_ptr;
            end
            if (push && state != ST_ERROR) xfer_count <= xfer_count + 1'b1;
        end
    end

    assign estado     = state;
    assign idle       = (state == ST_IDLE);
    assign pausa      = (state == ST_PAUSE);
    assign error_full = (state == ST_ERROR);

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed self-checking bench for rr_arbiter_ctrl; a second instance with a
// 4-bit counter shares all inputs to exercise counter wrap.
module tb_rr_arbiter_ctrl;
    import rr_arbiter_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset, iniciar, almost_full, full;
    logic [3:0] empty;

    logic [3:0]  pop, pop4;
    logic        push, push4;
    logic [1:0]  sel, sel4;
    logic [2:0]  estado, estado4;
    logic        idle, pausa, error_full, idle4, pausa4, error_full4;
    logic [15:0] xfer_count;
    logic [3:0]  xfer_count4;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_ctrl #(.N(4), .SELW(2), .CNTW(16)) u_dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .empty(empty),
        .almost_full(almost_full), .full(full), .pop(pop), .push(push),
        .sel(sel), .estado(estado), .idle(idle), .pausa(pausa),
        .error_full(error_full), .xfer_count(xfer_count)
    );

    rr_arbiter_ctrl #(.N(4), .SELW(2), .CNTW(4)) u_dut4 (
        .clk(clk), .reset(reset), .iniciar(iniciar), .empty(empty),
        .almost_full(almost_full), .full(full), .pop(pop4), .push(push4),
        .sel(sel4), .estado(estado4), .idle(idle4), .pausa(pausa4),
        .error_full(error_full4), .xfer_count(xfer_count4)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; iniciar = 1'b0; empty = 4'b1111; almost_full = 1'b0; full = 1'b0;
        tick(); tick();
        n_checks++; if (estado !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %b expected 000", estado); end
        n_checks++; if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b expected 0", push); end
        n_checks++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", xfer_count); end
        n_checks++; if ({idle, pausa, error_full} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {idle, pausa, error_full}); end
        n_checks++; if (pop !== 4'b0000) begin n_fail++; $display("FAIL reset_pop: got %b expected 0000", pop); end
        reset = 1'b0;
    endtask

    task automatic test_init_idle;
        tick();
        n_checks++; if (estado !== 3'b000) begin n_fail++; $display("FAIL init_hold: got %b expected 000", estado); end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++; if (estado !== 3'b001) begin n_fail++; $display("FAIL init_to_idle: got %b expected 001", estado); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL idle_flag: got %b expected 1", idle); end
        n_checks++; if (pop !== 4'b0000) begin n_fail++; $display("FAIL idle_pop: got %b expected 0000", pop); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_pop;
        logic [1:0] exp_sel;
        empty = 4'b0000;
        #1;
        n_checks++; if (pop !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_pop: got %b expected 0000", pop); end
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_pop = 4'(1 << (k % 4));
            n_checks++; if (pop !== exp_pop) begin n_fail++; $display("FAIL rr_pop%0d: got %b expected %b", k, pop, exp_pop); end
            if (k > 0) begin
                exp_sel = 2'((k - 1) % 4);
                n_checks++; if (push !== 1'b1 || sel !== exp_sel) begin n_fail++; $display("FAIL rr_push%0d: got push=%b sel=%0d expected push=1 sel=%0d", k, push, sel, exp_sel); end
            end
            tick();
        end
        empty = 4'b1111;
        #1;
        n_checks++; if (pop !== 4'b0000 || push !== 1'b1 || sel !== 2'd0) begin n_fail++; $display("FAIL rr_drain: got pop=%b push=%b sel=%0d expected pop=0000 push=1 sel=0", pop, push, sel); end
        tick();
        n_checks++; if (estado !== 3'b001 || push !== 1'b0) begin n_fail++; $display("FAIL rr_to_idle: got state=%b push=%b expected state=001 push=0", estado, push); end
        n_checks++; if (xfer_count !== 16'd5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", xfer_count); end
    endtask

    task automatic test_skip_empty;
        logic [3:0] exp_pop [3];
        logic [1:0] exp_sel [3];
        exp_pop = '{4'b0100, 4'b0001, 4'b0100};
        exp_sel = '{2'd0, 2'd2, 2'd0};
        empty = 4'b1010;
        tick();
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (pop !== exp_pop[j]) begin n_fail++; $display("FAIL skip_pop%0d: got %b expected %b", j, pop, exp_pop[j]); end
            if (j > 0) begin
                n_checks++; if (push !== 1'b1 || sel !== exp_sel[j]) begin n_fail++; $display("FAIL skip_push%0d: got push=%b sel=%0d expected push=1 sel=%0d", j, push, sel, exp_sel[j]); end
            end
            tick();
        end
    endtask

    task automatic test_pause;
        almost_full = 1'b1;
        #1;
        n_checks++; if (pop !== 4'b0000 || push !== 1'b1 || sel !== 2'd2) begin n_fail++; $display("FAIL af_cycle: got pop=%b push=%b sel=%0d expected pop=0000 push=1 sel=2", pop, push, sel); end
        tick();
        n_checks++; if (estado !== 3'b011 || pausa !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL pause_enter: got state=%b pausa=%b idle=%b expected 011 1 0", estado, pausa, idle); end
        n_checks++; if (xfer_count !== 16'd8) begin n_fail++; $display("FAIL pause_count: got %0d expected 8", xfer_count); end
        empty = 4'b0000;
        tick();
        n_checks++; if (pausa !== 1'b1 || pop !== 4'b0000 || push !== 1'b0) begin n_fail++; $display("FAIL pause_hold: got pausa=%b pop=%b push=%b expected 1 0000 0", pausa, pop, push); end
        almost_full = 1'b0;
        tick();
        n_checks++; if (estado !== 3'b010 || pop !== 4'b1000) begin n_fail++; $display("FAIL resume_ptr: got state=%b pop=%b expected 010 1000", estado, pop); end
        tick();
        n_checks++; if (pop !== 4'b0001 || push !== 1'b1 || sel !== 2'd3) begin n_fail++; $display("FAIL resume_next: got pop=%b push=%b sel=%0d expected 0001 1 3", pop, push, sel); end
    endtask

    task automatic test_overflow;
        full = 1'b1;
        tick();
        full = 1'b0;
        n_checks++; if (estado !== 3'b100 || error_full !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got state=%b error_full=%b expected 100 1", estado, error_full); end
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (pop !== 4'b0000 || error_full !== 1'b1 || idle !== 1'b0 || pausa !== 1'b0) begin n_fail++; $display("FAIL err_sticky%0d: got pop=%b err=%b idle=%b pausa=%b expected 0000 1 0 0", j, pop, error_full, idle, pausa); end
            tick();
        end
        n_checks++; if (xfer_count !== 16'd9) begin n_fail++; $display("FAIL err_count_hold: got %0d expected 9", xfer_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (estado !== 3'b000 || xfer_count !== 16'd0 || error_full !== 1'b0) begin n_fail++; $display("FAIL err_reset: got state=%b count=%0d err=%b expected 000 0 0", estado, xfer_count, error_full); end
    endtask

    task automatic test_reset_mid;
        empty = 4'b1111; iniciar = 1'b1;
        tick();
        iniciar = 1'b0; empty = 4'b0000;
        tick();
        n_checks++; if (pop !== 4'b0001) begin n_fail++; $display("FAIL ptr_after_reset: got %b expected 0001", pop); end
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (push !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got push=%b expected 1", push); end
        tick();
        n_checks++; if (push !== 1'b0 || estado !== 3'b000 || xfer_count !== 16'd0) begin n_fail++; $display("FAIL mid_reset: got push=%b state=%b count=%0d expected 0 000 0", push, estado, xfer_count); end
        reset = 1'b0;
        tick();
        n_checks++; if (push !== 1'b0 || pop !== 4'b0000 || estado !== 3'b000) begin n_fail++; $display("FAIL post_reset: got push=%b pop=%b state=%b expected 0 0000 000", push, pop, estado); end
    endtask

    task automatic test_count_wrap;
        empty = 4'b1111; iniciar = 1'b1;
        tick();
        iniciar = 1'b0; empty = 4'b0000;
        tick();
        repeat (17) tick();
        empty = 4'b1111;
        tick();
        n_checks++; if (xfer_count !== 16'd17) begin n_fail++; $display("FAIL count17: got %0d expected 17", xfer_count); end
        n_checks++; if (xfer_count4 !== 4'd1) begin n_fail++; $display("FAIL count_wrap4: got %0d expected 1", xfer_count4); end
        n_checks++; if (estado4 !== 3'b001) begin n_fail++; $display("FAIL wrap_idle: got %b expected 001", estado4); end
    endtask

    initial begin
        test_reset();
        test_init_idle();
        test_round_robin();
        test_skip_empty();
        test_pause();
        test_overflow();
        test_reset_mid();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
